banked_result_checker: RTL and testbench

- Synthesizable on-chip result checker for the CNN accelerator, a parametrised successor to the bench-side output comparison.
- Walks a multi-bank output SRAM in linear word order; bank = index / BANK_WORDS, address = index % BANK_WORDS.
- Compares the low ELEM_W bits of each word against a streamed golden value with a configurable tolerance.
- Reports error count, first failing index and per-error detail; sits beside the Output SRAM read port during self-test.

---
 rtl/chk_pkg.sv | 16 +
 rtl/chk_fifo.sv | 53 +++++
 rtl/banked_result_checker.sv | 177 +++++++++++++++++
 tb/tb_banked_result_checker.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chk_pkg.sv
// Shared types and constants for the banked output-SRAM result checker.
package chk_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } chk_state_e;

    function automatic int unsigned total_words(input int unsigned num_banks,
                                                input int unsigned bank_words);
        return num_banks * bank_words;
    endfunction

endpackage

// File: rtl/chk_fifo.sv
// Small synchronous FIFO holding returned SRAM elements until the golden stream consumes them.
module chk_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is still accepted when a pop frees a slot this cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/banked_result_checker.sv
// Walks a multi-bank output SRAM in linear order and compares each element
// against a streamed golden value within a tolerance, reporting error statistics.
module banked_result_checker
    import chk_pkg::*;
#(
    parameter int unsigned BANK_WORDS = 32768,
    parameter int unsigned NUM_BANKS  = 6,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ELEM_W     = 8,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned CNT_W      = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [CNT_W-1:0]              num_words_i,
    input  logic [ELEM_W-1:0]             tol_i,
    output logic                          mem_cs_o,
    output logic [$clog2(NUM_BANKS)-1:0]  mem_bank_o,
    output logic [$clog2(BANK_WORDS)-1:0] mem_addr_o,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    input  logic                          gold_valid_i,
    input  logic [ELEM_W-1:0]             gold_data_i,
    output logic                          gold_ready_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic                          cfg_err_o,
    output logic [CNT_W-1:0]              err_cnt_o,
    output logic [CNT_W-1:0]              chk_cnt_o,
    output logic [CNT_W-1:0]              first_err_idx_o,
    output logic                          err_valid_o,
    output logic [CNT_W-1:0]              err_idx_o,
    output logic [ELEM_W-1:0]             err_got_o,
    output logic [ELEM_W-1:0]             err_exp_o
);

    localparam int unsigned BANK_W    = $clog2(NUM_BANKS);
    localparam int unsigned ADDR_W    = $clog2(BANK_WORDS);
    localparam int unsigned OUT_W     = $clog2(RD_LAT + 2);
    localparam logic [CNT_W:0] TOTAL_CNT = (CNT_W + 1)'(total_words(NUM_BANKS, BANK_WORDS));

    chk_state_e        state_q, state_d;
    logic [CNT_W-1:0]  num_q, issue_cnt_q, chk_cnt_q, err_cnt_q, first_err_q, err_idx_q;
    logic [ELEM_W-1:0] tol_q, err_got_q, err_exp_q;
    logic [BANK_W-1:0] bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [OUT_W-1:0]  out_cnt_q;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic              err_valid_q, cfg_err_q, pass_q;

    logic              start_ok, oversize, gold_hs, mismatch, fifo_empty, unused_fifo_full;
    logic [ELEM_W-1:0] fifo_rdata;
    logic [ELEM_W:0]   diff, mag;
    logic              unused_rdata_hi;

    assign unused_rdata_hi = ^mem_rdata_i[DATA_W-1:ELEM_W];

    chk_fifo #(
        .WIDTH (ELEM_W),
        .DEPTH (RD_LAT + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_q[RD_LAT-1]),
        .wdata (mem_rdata_i[ELEM_W-1:0]),
        .pop   (gold_hs),
        .rdata (fifo_rdata),
        .full  (unused_fifo_full),
        .empty (fifo_empty)
    );

    if (RD_LAT == 1) begin : g_vld_one
        assign vld_d = mem_cs_o;
    end else begin : g_vld_multi
        assign vld_d = {vld_q[RD_LAT-2:0], mem_cs_o};
    end

    assign start_ok     = start_i && (state_q == StIdle || state_q == StDone);
    assign oversize     = {1'b0, num_words_i} > TOTAL_CNT;
    assign gold_ready_o = !fifo_empty && (state_q == StRun || state_q == StDrain);
    assign gold_hs      = gold_valid_i && gold_ready_o;
    // Credit counts a same-cycle pop so a steady stream sustains one read per cycle.
    assign mem_cs_o     = (state_q == StRun) && (issue_cnt_q < num_q) &&
                          ((out_cnt_q - OUT_W'(gold_hs)) < OUT_W'(RD_LAT + 1));

    assign diff     = {fifo_rdata[ELEM_W-1], fifo_rdata} - {gold_data_i[ELEM_W-1], gold_data_i};
    assign mag      = diff[ELEM_W] ? (~diff + (ELEM_W + 1)'(1)) : diff;
    assign mismatch = mag > {1'b0, tol_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = (num_words_i == '0 || oversize) ? StDone : StRun;
            StRun:   if (issue_cnt_q == num_q) state_d = StDrain;
            StDrain: if (chk_cnt_q == num_q) state_d = StDone;
            StDone: begin
                state_d = StIdle;
                if (start_ok) state_d = (num_words_i == '0 || oversize) ? StDone : StRun;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            num_q       <= '0;
            tol_q       <= '0;
            issue_cnt_q <= '0;
            bank_q      <= '0;
            addr_q      <= '0;
            out_cnt_q   <= '0;
            vld_q       <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '1;
            err_valid_q <= 1'b0;
            err_idx_q   <= '0;
            err_got_q   <= '0;
            err_exp_q   <= '0;
            cfg_err_q   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_q       <= vld_d;
            out_cnt_q   <= out_cnt_q + OUT_W'(mem_cs_o) - OUT_W'(gold_hs);
            err_valid_q <= gold_hs && mismatch;
            if (start_ok) begin
                num_q       <= num_words_i;
                tol_q       <= tol_i;
                issue_cnt_q <= '0;
                bank_q      <= '0;
                addr_q      <= '0;
                chk_cnt_q   <= '0;
                err_cnt_q   <= '0;
                first_err_q <= '1;
                cfg_err_q   <= oversize;
                pass_q      <= (num_words_i == '0) && !oversize;
            end
            if (mem_cs_o) begin
                issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                if (addr_q == ADDR_W'(BANK_WORDS - 1)) begin
                    addr_q <= '0;
                    bank_q <= bank_q + BANK_W'(1);
                end else begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
            end
            if (gold_hs) begin
                chk_cnt_q <= chk_cnt_q + CNT_W'(1);
                if (mismatch) begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                    if (err_cnt_q == '0) first_err_q <= chk_cnt_q;
                    err_idx_q <= chk_cnt_q;
                    err_got_q <= fifo_rdata;
                    err_exp_q <= gold_data_i;
                end
            end
            if (state_q == StDrain && state_d == StDone) pass_q <= (err_cnt_q == '0);
        end
    end

    assign mem_bank_o      = bank_q;
    assign mem_addr_o      = addr_q;
    assign busy_o          = (state_q == StRun) || (state_q == StDrain);
    assign done_o          = (state_q == StDone);
    assign pass_o          = pass_q;
    assign cfg_err_o       = cfg_err_q;
    assign err_cnt_o       = err_cnt_q;
    assign chk_cnt_o       = chk_cnt_q;
    assign first_err_idx_o = first_err_q;
    assign err_valid_o     = err_valid_q;
    assign err_idx_o       = err_idx_q;
    assign err_got_o       = err_got_q;
    assign err_exp_o       = err_exp_q;

endmodule

// File: tb/tb_banked_result_checker.sv
// Self-checking bench: table of check runs plus hand sequences for restart-while-busy and reset mid-run.
module tb_banked_result_checker;

    localparam int unsigned BANK_WORDS = 8;
    localparam int unsigned NUM_BANKS  = 3;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned ELEM_W     = 8;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned CNT_W      = 8;
    localparam int          TOTAL      = 24;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [CNT_W-1:0]  num_words_i;
    logic [ELEM_W-1:0] tol_i;
    logic              mem_cs_o;
    logic [1:0]        mem_bank_o;
    logic [2:0]        mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              gold_valid_i;
    logic [ELEM_W-1:0] gold_data_i;
    logic              gold_ready_o, busy_o, done_o, pass_o, cfg_err_o, err_valid_o;
    logic [CNT_W-1:0]  err_cnt_o, chk_cnt_o, first_err_idx_o, err_idx_o;
    logic [ELEM_W-1:0] err_got_o, err_exp_o;

    always #5 clk = ~clk;

    banked_result_checker #(
        .BANK_WORDS (BANK_WORDS),
        .NUM_BANKS  (NUM_BANKS),
        .DATA_W     (DATA_W),
        .ELEM_W     (ELEM_W),
        .RD_LAT     (RD_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .num_words_i     (num_words_i),
        .tol_i           (tol_i),
        .mem_cs_o        (mem_cs_o),
        .mem_bank_o      (mem_bank_o),
        .mem_addr_o      (mem_addr_o),
        .mem_rdata_i     (mem_rdata_i),
        .gold_valid_i    (gold_valid_i),
        .gold_data_i     (gold_data_i),
        .gold_ready_o    (gold_ready_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .cfg_err_o       (cfg_err_o),
        .err_cnt_o       (err_cnt_o),
        .chk_cnt_o       (chk_cnt_o),
        .first_err_idx_o (first_err_idx_o),
        .err_valid_o     (err_valid_o),
        .err_idx_o       (err_idx_o),
        .err_got_o       (err_got_o),
        .err_exp_o       (err_exp_o)
    );

    typedef struct {
        int n; int tol; int goff; int ov_idx; int ov_mem; int ov_gold; int vmode;
        int exp_err; int exp_first; int exp_pass; int exp_cfg; int restart;
    } vec_t;
    typedef struct { int idx; int got; int exp; } err_t;

    int                vec_cnt = 0;
    int                fail_cnt = 0;
    string             cur_tag = "reset";
    logic [DATA_W-1:0] mem [TOTAL];
    logic [ELEM_W-1:0] gold_arr [TOTAL];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    err_t              sb [$];
    int                gptr, gold_lim, tol_cur, vmode, phase, rd_idx, rd_cnt, outstanding, err_pulses;
    bit                run_en;
    vec_t              tbl [14];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            fail_cnt++;
            $display("FAIL [%s] %s: got %0d, expected %0d", cur_tag, name, act, exp);
        end
    endtask

    // SRAM model with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        int li;
        li = int'(mem_bank_o) * BANK_WORDS + int'(mem_addr_o);
        rd_pipe[0] <= (mem_cs_o && li < TOTAL) ? mem[li] : '0;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata_i = rd_pipe[RD_LAT-1];

    // Read-order, credit and scoreboard push on every golden handshake.
    always @(posedge clk) begin
        if (!rst) begin
            if (mem_cs_o) begin
                check("rd_bank", int'(mem_bank_o), rd_idx / BANK_WORDS);
                check("rd_addr", int'(mem_addr_o), rd_idx % BANK_WORDS);
                rd_idx++;
                rd_cnt++;
                outstanding++;
            end
            if (gold_valid_i && gold_ready_o) begin
                int got, ex, d;
                got = int'($signed(mem[gptr][ELEM_W-1:0]));
                ex  = int'($signed(gold_arr[gptr]));
                d   = got - ex;
                if (d < 0) d = -d;
                if (d > tol_cur) sb.push_back('{gptr, got, ex});
                gptr++;
                outstanding--;
            end
            if (mem_cs_o) check("outstanding_ok", (outstanding <= RD_LAT + 1) ? 1 : 0, 1);
        end
    end

    always @(negedge clk) begin
        bit v;
        phase = (phase + 1) % 3;
        case (vmode)
            0:       v = 1'b1;
            1:       v = (phase == 0);
            default: v = ($urandom_range(0, 1) == 1);
        endcase
        gold_valid_i = run_en && v && (gptr < gold_lim);
        gold_data_i  = (gptr < TOTAL) ? gold_arr[gptr] : '0;
    end

    always @(negedge clk) begin
        if (!rst && err_valid_o) begin
            err_pulses++;
            check("err_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                err_t e;
                e = sb.pop_front();
                check("err_idx", int'(err_idx_o), e.idx);
                check("err_got", int'($signed(err_got_o)), e.got);
                check("err_exp", int'($signed(err_exp_o)), e.exp);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_pass", int'(pass_o), 0);
        check("rst_cfg_err", int'(cfg_err_o), 0);
        check("rst_err_cnt", int'(err_cnt_o), 0);
        check("rst_chk_cnt", int'(chk_cnt_o), 0);
        check("rst_first_err", int'(first_err_idx_o), 255);
        check("rst_err_valid", int'(err_valid_o), 0);
        check("rst_mem_cs", int'(mem_cs_o), 0);
        check("rst_gold_ready", int'(gold_ready_o), 0);
        check("rst_err_detail", int'(err_idx_o) + int'(err_got_o) + int'(err_exp_o), 0);
    endtask

    task automatic setup_vec(input vec_t v);
        for (int i = 0; i < TOTAL; i++) begin
            logic [7:0] el;
            el          = (i == v.ov_idx) ? 8'(v.ov_mem) : 8'(i);
            mem[i]      = {8'(i * 37 + 11), el};
            gold_arr[i] = (i == v.ov_idx) ? 8'(v.ov_gold) : 8'(i + v.goff);
        end
        gptr = 0; rd_idx = 0; rd_cnt = 0; outstanding = 0; err_pulses = 0;
        sb.delete();
        tol_cur  = v.tol;
        vmode    = v.vmode;
        gold_lim = (v.n > TOTAL) ? 0 : v.n;
    endtask

    task automatic start_vec(input vec_t v);
        @(posedge clk); #1;
        start_i     = 1'b1;
        num_words_i = CNT_W'(v.n);
        tol_i       = ELEM_W'(v.tol);
        run_en      = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cycles, exp_chk, exp_lat;
        setup_vec(v);
        start_vec(v);
        cycles = 1;
        while (!done_o && cycles < 300) begin
            if (v.restart != 0 && cycles == 4) begin
                start_i = 1'b1; num_words_i = 3; tol_i = 0;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        start_i = 1'b0;
        check("done_seen", int'(done_o), 1);
        exp_chk = (v.n > TOTAL) ? 0 : v.n;
        if (v.vmode == 0) begin
            exp_lat = (v.n == 0 || v.n > TOTAL) ? 1 : v.n + RD_LAT + 3;
            check("latency", cycles, exp_lat);
        end
        check("busy_at_done", int'(busy_o), 0);
        check("pass", int'(pass_o), v.exp_pass);
        check("cfg_err", int'(cfg_err_o), v.exp_cfg);
        check("chk_cnt", int'(chk_cnt_o), exp_chk);
        check("err_cnt", int'(err_cnt_o), v.exp_err);
        check("first_err_idx", int'(first_err_idx_o), v.exp_first);
        check("reads_issued", rd_cnt, exp_chk);
        check("err_pulses", err_pulses, v.exp_err);
        check("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", int'(done_o), 0);
        check("pass_held", int'(pass_o), v.exp_pass);
        run_en = 1'b0;
    endtask

    initial begin
        int cycles, bad;
        rst = 1'b1; start_i = 1'b0; num_words_i = '0; tol_i = '0; run_en = 1'b0;
        gold_valid_i = 1'b0; gold_data_i = '0;
        vmode = 0; phase = 0; gptr = 0; gold_lim = 0; tol_cur = 0;
        for (int i = 0; i < TOTAL; i++) begin
            mem[i] = '0;
            gold_arr[i] = '0;
        end
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        //            n  tol goff ov  ovm  ovg vm err first pass cfg rs
        tbl[0]  = '{10,   1,  0, -1,   0,   0, 0,  0, 255, 1, 0, 0};
        tbl[1]  = '{10,   1,  1, -1,   0,   0, 0,  0, 255, 1, 0, 0};
        tbl[2]  = '{10,   1,  1,  4,   4,   6, 0,  1,   4, 0, 0, 0};
        tbl[3]  = '{ 5,   1,  0,  2, 128, 127, 0,  1,   2, 0, 0, 0};
        tbl[4]  = '{ 5, 255,  0,  2, 128, 127, 0,  0, 255, 1, 0, 0};
        tbl[5]  = '{20,   0,  0,  8,   8,   9, 0,  1,   8, 0, 0, 0};
        tbl[6]  = '{24,   2, -2, -1,   0,   0, 1,  0, 255, 1, 0, 0};
        tbl[7]  = '{24,   0,  0, 23,  23,  28, 2,  1,  23, 0, 0, 0};
        tbl[8]  = '{ 0,   1,  0, -1,   0,   0, 0,  0, 255, 1, 0, 0};
        tbl[9]  = '{25,   1,  0, -1,   0,   0, 0,  0, 255, 0, 1, 0};
        tbl[10] = '{ 1,   0,  0, -1,   0,   0, 0,  0, 255, 1, 0, 0};
        tbl[11] = '{ 6,   0,  1, -1,   0,   0, 0,  6,   0, 0, 0, 0};
        tbl[12] = '{24,   3,  0,  0, 127, 128, 1,  1,   0, 0, 0, 0};
        tbl[13] = '{10,   1,  1, -1,   0,   0, 0,  0, 255, 1, 0, 1};

        for (int t = 0; t < 14; t++) begin
            cur_tag = $sformatf("vec%0d", t);
            run_vec(tbl[t]);
        end

        // Reset asserted once five compares have registered.
        cur_tag = "reset_mid_run";
        setup_vec('{20, 0, 0, -1, 0, 0, 0, 0, 255, 1, 0, 0});
        start_vec('{20, 0, 0, -1, 0, 0, 0, 0, 255, 1, 0, 0});
        cycles = 0;
        while (chk_cnt_o != 5 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("reached_cmp5", int'(chk_cnt_o), 5);
        rst = 1'b1;
        run_en = 1'b0;
        #1;
        check_reset_vals();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        bad = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_o || mem_cs_o || busy_o) bad++;
        end
        check("quiet_after_reset", bad, 0);
        check("chk_cnt_after_reset", int'(chk_cnt_o), 0);

        cur_tag = "after_reset";
        run_vec(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
